// File: rtl/parity_pkg.sv
// Shared parity-link types: frame FSM states and parity-sense constants.
// Imported by the serial parity generator and checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    PAR  = 2'b10
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Bit-index width, never below one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/parity_err_counter.sv
// 8-bit saturating parity-error counter, cleared only by reset.
// Ports: clk, reset (async high), inc (count one error), cnt (current count).
module parity_err_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (inc && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W bits LSB first plus parity -> word + error.
// Ports: clk, reset (async high), i_valid/i_x/i_clear in; o_data, o_valid,
// o_err, o_busy out; o_err_cnt only with PARITY_CHK_ERR_CNT_EN defined.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter bit PARITY_ODD = EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_x,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_busy
`ifdef PARITY_CHK_ERR_CNT_EN
  ,
  output logic [7:0]        o_err_cnt
`endif
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              acc, acc_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic              done;
  logic              err_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    word_nxt  = word;
    done      = 1'b0;
    err_nxt   = acc ^ i_x ^ PARITY_ODD;
    if (i_clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      acc_nxt   = 1'b0;
      word_nxt  = '0;
    end else if (i_valid) begin
      unique case (1'b1)
        (state == IDLE): begin
          word_nxt    = '0;
          word_nxt[0] = i_x;
          acc_nxt     = i_x;
          if (DATA_W == 1) begin
            state_nxt = PAR;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = CNT_W'(1);
          end
        end
        (state == DATA): begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CNT_W'(i)) word_nxt[i] = i_x;
          end
          acc_nxt = acc ^ i_x;
          if (cnt == LAST) state_nxt = PAR;
          else cnt_nxt = cnt + CNT_W'(1);
        end
        (state == PAR): begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          acc_nxt   = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          acc_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= 1'b0;
      word    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      word    <= word_nxt;
      o_valid <= done;
      // busy is decoded from the next state so it lines up with state
      o_busy  <= (state_nxt != IDLE);
      if (done) begin
        o_data <= word;
        o_err  <= err_nxt;
      end
    end
  end

`ifdef PARITY_CHK_ERR_CNT_EN
  parity_err_counter u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (done && err_nxt),
    .cnt   (o_err_cnt)
  );
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: directed frames plus random stream
// checked against a frame-level parity model; even and odd instances.
module tb_serial_parity_checker;

  localparam int DW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } frm_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_valid = 1'b0;
  logic i_x = 1'b0;
  logic i_clear = 1'b0;

  logic [DW-1:0] d_e, d_o;
  logic v_e, v_o, e_e, e_o, b_e, b_o;
`ifdef PARITY_CHK_ERR_CNT_EN
  logic [7:0] c_e, c_o;
`endif

  serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_x(i_x),
    .i_clear(i_clear), .o_data(d_e), .o_valid(v_e), .o_err(e_e),
    .o_busy(b_e)
`ifdef PARITY_CHK_ERR_CNT_EN
    , .o_err_cnt(c_e)
`endif
  );

  serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_x(i_x),
    .i_clear(i_clear), .o_data(d_o), .o_valid(v_o), .o_err(e_o),
    .o_busy(b_o)
`ifdef PARITY_CHK_ERR_CNT_EN
    , .o_err_cnt(c_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  bit   mq[$];
  frm_t exp_e[$], exp_o[$];
  frm_t got_e[$], got_o[$];
  int   vpos[$];

  // Frame-level model: collect accepted bits, close a frame at DW+1 bits.
  task automatic model(input logic v, input logic x, input logic c);
    frm_t f;
    int ones;
    if (c) begin
      mq.delete();
    end else if (v) begin
      mq.push_back(x);
      if (mq.size() == DW + 1) begin
        ones = 0;
        f.d = '0;
        for (int i = 0; i <= DW; i++) begin
          if (mq[i]) ones++;
          if (i < DW) f.d[i] = mq[i];
        end
        f.e = (ones % 2) != 0;
        exp_e.push_back(f);
        f.e = (ones % 2) == 0;
        exp_o.push_back(f);
        mq.delete();
      end
    end
  endtask

  task automatic cyc(input logic v, input logic x, input logic c);
    i_valid = v;
    i_x = x;
    i_clear = c;
    model(v, x, c);
    @(posedge clk);
    #1;
    cyc_n++;
    if (v_e) begin
      got_e.push_back({d_e, e_e});
      vpos.push_back(cyc_n);
    end
    if (v_o) got_o.push_back({d_o, e_o});
  endtask

  task automatic clr_q();
    exp_e.delete();
    exp_o.delete();
    got_e.delete();
    got_o.delete();
    vpos.delete();
  endtask

  task automatic frame(input logic [DW:0] b);
    for (int i = 0; i <= DW; i++) cyc(1'b1, b[i], 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_e, v_e, e_e, b_e} !== '0) begin
      n_bad++;
      $display("FAIL reset_even: got %b want 0", {d_e, v_e, e_e, b_e});
    end
    n_cmp++;
    if ({d_o, v_o, e_o, b_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_odd: got %b want 0", {d_o, v_o, e_o, b_o});
    end
`ifdef PARITY_CHK_ERR_CNT_EN
    n_cmp++;
    if (c_e !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d want 0", c_e);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_basic();
    clr_q();
    frame(4'b0101);
    n_cmp++;
    if ({v_e, d_e, e_e} !== {1'b1, 3'b101, 1'b0}) begin
      n_bad++;
      $display("FAIL basic: got v%b d%b e%b want v1 d101 e0",
               v_e, d_e, e_e);
    end
    n_cmp++;
    if ({v_o, e_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL basic_odd: got v%b e%b want v1 e1", v_o, e_o);
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({v_e, d_e, e_e} !== {1'b0, 3'b101, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_hold: got v%b d%b e%b want v0 d101 e0",
               v_e, d_e, e_e);
    end
  endtask

  task automatic test_err();
    clr_q();
    frame(4'b0111);
    n_cmp++;
    if ({v_e, d_e, e_e} !== {1'b1, 3'b111, 1'b1}) begin
      n_bad++;
      $display("FAIL err: got v%b d%b e%b want v1 d111 e1",
               v_e, d_e, e_e);
    end
    cyc(1'b0, 1'b0, 1'b0);
`ifdef PARITY_CHK_ERR_CNT_EN
    n_cmp++;
    if (c_e !== 8'd1) begin
      n_bad++;
      $display("FAIL err_cnt1: got %0d want 1", c_e);
    end
`endif
    for (int k = 0; k < 259; k++) frame(4'b0111);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== 260) begin
      n_bad++;
      $display("FAIL err_frames: got %0d want 260", got_e.size());
    end
`ifdef PARITY_CHK_ERR_CNT_EN
    n_cmp++;
    if (c_e !== 8'd255) begin
      n_bad++;
      $display("FAIL err_cnt_sat: got %0d want 255", c_e);
    end
`endif
  endtask

  task automatic test_gaps();
    logic [DW:0] b;
    int bad_busy;
    clr_q();
    b = 4'b0101;
    bad_busy = 0;
    n_cmp++;
    if (b_e !== 1'b0) begin
      n_bad++;
      $display("FAIL gaps_idle_busy: got %b want 0", b_e);
    end
    for (int i = 0; i <= DW; i++) begin
      cyc(1'b1, b[i], 1'b0);
      if (i < DW) begin
        for (int g = 0; g < 5; g++) begin
          if (b_e !== 1'b1) bad_busy++;
          cyc(1'b0, 1'b1, 1'b0);
        end
      end
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL gaps_busy: got %0d low cycles want 0", bad_busy);
    end
    n_cmp++;
    if ({v_e, d_e, e_e, b_e} !== {1'b1, 3'b101, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL gaps: got v%b d%b e%b b%b want v1 d101 e0 b0",
               v_e, d_e, e_e, b_e);
    end
  endtask

  task automatic test_back_to_back();
    clr_q();
    frame(4'b0101);
    frame(4'b0110);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 2", got_e.size());
    end else begin
      n_cmp++;
      if (vpos[1] - vpos[0] !== 4) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d want 4", vpos[1] - vpos[0]);
      end
      n_cmp++;
      if ({got_e[0], got_e[1]} !== {3'b101, 1'b0, 3'b110, 1'b0}) begin
        n_bad++;
        $display("FAIL b2b_data: got %b want 1010_1100",
                 {got_e[0], got_e[1]});
      end
    end
  endtask

  task automatic test_clear();
    clr_q();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({v_e, b_e, d_e, e_e} !== {1'b0, 1'b0, 3'b110, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_abort: got v%b b%b d%b e%b want v0 b0 d110 e0",
               v_e, b_e, d_e, e_e);
    end
    frame(4'b1100);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== 1 || got_e[0] !== {3'b100, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_frame: got n%0d %b want n1 1000",
               got_e.size(), {d_e, e_e});
    end
    clr_q();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    frame(4'b1100);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== 1 || got_e[0] !== {3'b100, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_coincident: got n%0d %b want n1 1000",
               got_e.size(), {d_e, e_e});
    end
  endtask

  task automatic test_reset_mid();
    clr_q();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    i_valid = 1'b0;
    reset = 1'b1;
    mq.delete();
    #1;
    n_cmp++;
    if ({d_e, v_e, e_e, b_e} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b want 0", {d_e, v_e, e_e, b_e});
    end
`ifdef PARITY_CHK_ERR_CNT_EN
    n_cmp++;
    if (c_e !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_cnt: got %0d want 0", c_e);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    frame(4'b1010);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== 1 || got_e[0] !== {3'b010, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_even: got n%0d %b want n1 0100",
               got_e.size(), {d_e, e_e});
    end
    n_cmp++;
    if (got_o.size() !== 1 || got_o[0] !== {3'b010, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_odd: got n%0d %b want n1 0101",
               got_o.size(), {d_o, e_o});
    end
  endtask

  task automatic test_random();
    int n;
    clr_q();
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 9) < 7), 1'($urandom),
          ($urandom_range(0, 99) < 3));
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_e.size() !== exp_e.size() || got_o.size() !== exp_o.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d/%0d want %0d/%0d",
               got_e.size(), got_o.size(), exp_e.size(), exp_o.size());
    end
    n = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_e[i] !== exp_e[i]) begin
        n_bad++;
        $display("FAIL rand_even[%0d]: got %b want %b",
                 i, got_e[i], exp_e[i]);
      end
    end
    n = (got_o.size() < exp_o.size()) ? got_o.size() : exp_o.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_o[i] !== exp_o[i]) begin
        n_bad++;
        $display("FAIL rand_odd[%0d]: got %b want %b",
                 i, got_o[i], exp_o[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receiver-side counterpart to the serial even-parity generator. Accepts a serial frame of DATA_W data bits followed by one parity bit, reassembles the data word, and flags a parity mismatch. It sits at the far end of the single-bit serial link and hands a parallel word plus error flag to downstream logic one cycle after the parity bit arrives.

## Interface
Parameters:
- DATA_W, 3, data bits per frame before the parity bit; legal range 1..32
- PARITY_ODD, 0, 0 = even parity (total ones in data+parity even), 1 = odd parity

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- i_valid  input  1  i_x carries a frame bit this cycle
- i_x  input  1  serial bit, data LSB first, then parity
- i_clear  input  1  synchronous abort of a partial frame
- o_data  output  DATA_W  last completed data word; holds until next frame completes
- o_valid  output  1  one-cycle pulse: o_data/o_err updated
- o_err  output  1  parity mismatch for the frame in o_data; holds with o_data
- o_busy  output  1  high while a frame is partially received (state DATA or PAR)
- o_err_cnt  output  8  saturating error count (only with PARITY_CHK_ERR_CNT_EN)

## Operation
- States: IDLE, DATA, PAR; 2-bit encoding in shared package.
- Bit counter cnt, width $clog2(DATA_W) (minimum 1); shift/index register holds partial word; running XOR acc.
- IDLE: on i_valid, store i_x at bit 0, acc = i_x; go DATA with cnt=1, or PAR directly if DATA_W==1.
- DATA: on i_valid, store i_x at bit cnt, acc ^= i_x; when cnt==DATA_W-1 go PAR, else cnt+1.
- PAR: on i_valid, err = acc ^ i_x ^ PARITY_ODD; load o_data from the partial word, o_err = err, pulse o_valid; go IDLE, cnt=0.
- i_valid low in any state: no change (stall, unlimited length).
- i_clear: go IDLE, cnt=0, acc=0, discard partial word; o_data/o_err unchanged; no o_valid. i_clear and i_valid in the same cycle: clear wins, bit discarded.
- Back-to-back frames: first bit of next frame accepted in the cycle after the parity bit (IDLE entered immediately).

## Timing
- Reset values: state IDLE, cnt 0, acc 0, o_data 0, o_valid 0, o_err 0, o_busy 0, o_err_cnt 0.
- Latency: o_valid/o_data/o_err registered; visible the cycle after the parity-bit edge.
- Minimum frame duration DATA_W+1 valid cycles; sustained throughput one frame per DATA_W+1 cycles.
- o_busy is a registered decode of state, so it follows state with no additional delay.
- Reset mid-frame: immediate return to IDLE; partial frame lost, no o_valid.

## Configuration
- PARITY_CHK_ERR_CNT_EN defined: o_err_cnt port present; increments on every o_valid with o_err=1; saturates at 255; cleared only by reset (not by i_clear).
- Undefined: o_err_cnt port and counter absent; all other behaviour identical.

## Structure
- Shared package parity_pkg: state typedef (IDLE/DATA/PAR), shared with generator; parity-sense constants EVEN=0, ODD=1.
- One sub-module is natural: parity_err_counter (8-bit saturating counter), instantiated only under PARITY_CHK_ERR_CNT_EN.

## Test plan
- DATA_W=3, even: bits 1,0,1 then parity 0 on consecutive cycles -> next cycle o_valid=1, o_data=3'b101, o_err=0.
- Bits 1,1,1, parity 0 -> o_data=3'b111, o_err=1; with macro, o_err_cnt=1; 260 such frames -> o_err_cnt=255.
- Same frame as test 1 with i_valid low for 5 cycles between each bit -> identical result; o_busy high throughout the gaps.
- Two frames back-to-back (1,0,1,0 then 0,1,1,0) -> two o_valid pulses 4 cycles apart; o_data 3'b101 then 3'b110, o_err 0 then 0.
- i_clear after 2 data bits, then full frame 0,0,1,1 -> only one o_valid, o_data=3'b100, o_err=0; i_clear coincident with a valid bit -> that bit ignored.
- Assert reset after the 2nd data bit -> all outputs 0, o_busy 0; the subsequent 0,1,0,1 frame -> o_data=3'b010, o_err=0; PARITY_ODD=1 with same frame -> o_err=1.
